// File: rtl/alu_mc_unit_if.sv
// Request/result bus for alu_mc_unit. The master modport is the issue/writeback
// side and the slave modport is the execution unit.
interface alu_mc_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_aluc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_zero;
  logic        out_carry;
  logic        out_negative;
  logic        out_overflow;

  modport master (
    output in_valid, in_a, in_b, in_aluc, out_ready,
    input  in_ready, out_valid, out_r, out_zero, out_carry, out_negative, out_overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_aluc, out_ready,
    output in_ready, out_valid, out_r, out_zero, out_carry, out_negative, out_overflow
  );
endinterface

// File: rtl/alu_mc_unit.sv
// Handshaked 32-bit ALU execution unit. Single-cycle ops resolve at the accept
// edge; shifts move one bit per cycle. Results are held until the consumer
// takes them, and completed handshakes are counted in op_count.
module alu_mc_unit #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_mc_unit_if.slave       bus,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  typedef enum logic [1:0] {SH_SRA, SH_SRL, SH_SLL} shift_kind_t;

  typedef struct packed {
    logic [31:0] r;
    logic        zero;
    logic        carry;
    logic        negative;
    logic        overflow;
  } result_t;

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_SUBU = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_LUI0 = 4'b1000;
  localparam logic [3:0] OP_LUI1 = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;

  state_t      state;
  result_t     res;
  result_t     alu_res;
  logic [31:0] sh_val;
  logic [4:0]  sh_cnt;
  shift_kind_t sh_kind;
  logic [31:0] step_val;
  logic        step_bit;
  logic        req_is_shift;
  logic [4:0]  req_shamt;

  // Single-cycle evaluation of every code; shifts by zero pass b through with
  // carry cleared, which is exactly what the iterative path would produce.
  function automatic result_t alu_eval(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] aluc);
    result_t     f;
    logic [32:0] sum;
    logic [32:0] diff;
    logic        lt_s;
    sum  = {1'b0, a} + {1'b0, b};
    // The top bit of the widened difference is the unsigned borrow, i.e. a < b.
    diff = {1'b0, a} - {1'b0, b};
    lt_s = $signed(a) < $signed(b);
    // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
    f = '0;
    case (aluc)
      OP_ADDU: begin
        f.r     = sum[31:0];
        f.carry = sum[32];
      end
      OP_ADD: begin
        f.r        = sum[31:0];
        f.overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUBU: begin
        f.r     = diff[31:0];
        f.carry = diff[32];
      end
      OP_SUB: begin
        f.r        = diff[31:0];
        f.overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_AND:           f.r = a & b;
      OP_OR:            f.r = a | b;
      OP_XOR:           f.r = a ^ b;
      OP_NOR:           f.r = ~(a | b);
      OP_LUI0, OP_LUI1: f.r = {b[15:0], 16'h0000};
      OP_SLTU: begin
        f.r     = {31'd0, diff[32]};
        f.carry = diff[32];
      end
      OP_SLT:           f.r = {31'd0, lt_s};
      default:          f.r = b;
    endcase
    f.zero     = (f.r == 32'd0);
    f.negative = f.r[31];
    // Set-less-than reports operand equality on zero, not the 0/1 result.
    if (aluc == OP_SLT || aluc == OP_SLTU) f.zero = (a == b);
    if (aluc == OP_SLT) f.negative = lt_s;
    return f;
  endfunction

  assign alu_res      = alu_eval(bus.in_a, bus.in_b, bus.in_aluc);
  assign req_is_shift = (bus.in_aluc[3:2] == 2'b11);
  assign req_shamt    = bus.in_a[4:0];

  // One-bit step of the shift register and the bit that falls off the end.
  always_comb begin
    step_val = sh_val;
    step_bit = 1'b0;
    case (sh_kind)
      SH_SRA: begin
        step_val = {sh_val[31], sh_val[31:1]};
        step_bit = sh_val[0];
      end
      SH_SRL: begin
        step_val = {1'b0, sh_val[31:1]};
        step_bit = sh_val[0];
      end
      default: begin
        step_val = {sh_val[30:0], 1'b0};
        step_bit = sh_val[31];
      end
    endcase
  end

  // Control FSM plus the result, shift-register and completion-counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      res      <= '0;
      sh_val   <= '0;
      sh_cnt   <= '0;
      sh_kind  <= SH_SRL;
      op_count <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register sees the pre-edge values of the others.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (req_is_shift && (req_shamt != 5'd0)) begin
              sh_val  <= bus.in_b;
              sh_cnt  <= req_shamt;
              sh_kind <= bus.in_aluc[1] ? SH_SLL : (bus.in_aluc[0] ? SH_SRL : SH_SRA);
              state   <= SHIFT;
            end else begin
              res   <= alu_res;
              state <= HOLD;
            end
          end
        end
        SHIFT: begin
          sh_val <= step_val;
          sh_cnt <= sh_cnt - 5'd1;
          if (sh_cnt == 5'd1) begin
            res.r        <= step_val;
            res.zero     <= (step_val == 32'd0);
            res.carry    <= step_bit;
            res.negative <= step_val[31];
            res.overflow <= 1'b0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            op_count <= op_count + COUNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is masked by reset so nothing is offered to the issue stage while held in reset.
  assign bus.in_ready     = rst_n && (state == IDLE);
  assign busy             = (state == SHIFT);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_r        = res.r;
  assign bus.out_zero     = res.zero;
  assign bus.out_carry    = res.carry;
  assign bus.out_negative = res.negative;
  assign bus.out_overflow = res.overflow;

  // A held result must stay put until the consumer takes it.
  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state == HOLD && !bus.out_ready) |=> (state == HOLD && $stable(res)));

endmodule

// File: tb/tb_alu_mc_unit.sv
// Directed bench for alu_mc_unit: each task drives one scenario and checks
// the result bus, flags, busy and op_count against hand-computed values.
module tb_alu_mc_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [CW-1:0] op_count;
  int            checks = 0;
  int            errors = 0;

  alu_mc_unit_if bus();

  alu_mc_unit #(.COUNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request for one edge; reports whether in_ready was high at that edge.
  // Returns at the falling edge right after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] aluc,
                       output logic ready_seen);
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_aluc  = aluc;
    bus.in_valid = 1'b1;
    ready_seen   = bus.in_ready;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Waits up to limit falling edges for out_valid.
  task automatic wait_out(input int limit, output int cycles, output bit timeout);
    cycles = 0;
    while (!bus.out_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    timeout = !bus.out_valid;
  endtask

  // Completes the output handshake from a falling edge.
  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    checks++; if ({bus.out_r, bus.out_zero, bus.out_carry, bus.out_negative, bus.out_overflow} !== 36'd0) begin
      errors++; $display("FAIL reset_result: got r=%h z%b c%b n%b v%b expected all 0", bus.out_r,
                         bus.out_zero, bus.out_carry, bus.out_negative, bus.out_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_addu();
    logic rdy;
    issue(32'h1C000E02, 32'hFFFFFFFF, 4'b0000, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL addu_accept: in_ready got %b expected 1", rdy); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addu_latency: out_valid got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_r !== 32'h1C000E01) begin errors++; $display("FAIL addu_r: got %h expected 1c000e01", bus.out_r); end
    checks++; if ({bus.out_carry, bus.out_zero, bus.out_overflow} !== 3'b100) begin
      errors++; $display("FAIL addu_flags: got c%b z%b v%b expected c1 z0 v0", bus.out_carry, bus.out_zero, bus.out_overflow);
    end
    take();
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL addu_count: got %0d expected 1", op_count); end
  endtask

  task automatic test_add_subu();
    logic rdy;
    int   cyc;
    bit   to;
    issue(32'h7FC00E60, 32'h7F39081E, 4'b0010, rdy);
    wait_out(4, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL add_timeout: out_valid got 0 expected 1"); end
    checks++; if (bus.out_r !== 32'hFEF9167E) begin errors++; $display("FAIL add_r: got %h expected fef9167e", bus.out_r); end
    checks++; if ({bus.out_overflow, bus.out_negative, bus.out_carry, bus.out_zero} !== 4'b1100) begin
      errors++; $display("FAIL add_flags: got v%b n%b c%b z%b expected v1 n1 c0 z0",
                         bus.out_overflow, bus.out_negative, bus.out_carry, bus.out_zero);
    end
    take();
    issue(32'h80380802, 32'h80380802, 4'b0001, rdy);
    wait_out(4, cyc, to);
    checks++; if (to) begin errors++; $display("FAIL subu_timeout: out_valid got 0 expected 1"); end
    checks++; if (bus.out_r !== 32'd0) begin errors++; $display("FAIL subu_r: got %h expected 00000000", bus.out_r); end
    checks++; if ({bus.out_zero, bus.out_carry} !== 2'b10) begin
      errors++; $display("FAIL subu_flags: got z%b c%b expected z1 c0", bus.out_zero, bus.out_carry);
    end
    take();
    checks++; if (op_count !== 4'd3) begin errors++; $display("FAIL subu_count: got %0d expected 3", op_count); end
  endtask

  task automatic test_sra();
    logic rdy;
    int   n;
    issue(32'd8, 32'hF0000080, 4'b1100, rdy);
    n = 0;
    while (busy && n < 40) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sra_in_ready_shift%0d: got %b expected 0", n, bus.in_ready); end
      bus.in_a     = 32'd1;
      bus.in_b     = 32'd1;
      bus.in_aluc  = 4'b0000;
      bus.in_valid = (n == 2 || n == 5);
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL sra_busy_cycles: got %0d expected 8", n); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sra_out_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_r !== 32'hFFF00000) begin errors++; $display("FAIL sra_r: got %h expected fff00000", bus.out_r); end
    checks++; if ({bus.out_carry, bus.out_negative, bus.out_zero, bus.out_overflow} !== 4'b1100) begin
      errors++; $display("FAIL sra_flags: got c%b n%b z%b v%b expected c1 n1 z0 v0",
                         bus.out_carry, bus.out_negative, bus.out_zero, bus.out_overflow);
    end
    checks++; if (op_count !== 4'd3) begin errors++; $display("FAIL sra_count_before: got %0d expected 3", op_count); end
    take();
    checks++; if (op_count !== 4'd4) begin errors++; $display("FAIL sra_count_after: got %0d expected 4", op_count); end
  endtask

  task automatic test_sll_hold();
    logic rdy;
    int   cyc;
    bit   to;
    issue(32'd8, 32'hFF0F0000, 4'b1111, rdy);
    wait_out(20, cyc, to);
    checks++; if (to || cyc != 8) begin errors++; $display("FAIL sll_latency: got %0d cycles (timeout %b) expected 8", cyc, to); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.out_valid, bus.out_r, bus.out_carry} !== {1'b1, 32'h0F000000, 1'b1}) begin
        errors++; $display("FAIL sll_hold%0d: got valid=%b r=%h c=%b expected valid=1 r=0f000000 c=1",
                           i, bus.out_valid, bus.out_r, bus.out_carry);
      end
      checks++; if (op_count !== 4'd4) begin errors++; $display("FAIL sll_hold_count%0d: got %0d expected 4", i, op_count); end
      @(negedge clk);
    end
    take();
    checks++; if (op_count !== 4'd5) begin errors++; $display("FAIL sll_count: got %0d expected 5", op_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sll_release: out_valid got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_slt();
    logic rdy;
    int   cyc;
    bit   to;
    issue(32'hF0380802, 32'hF0380802, 4'b1010, rdy);
    wait_out(4, cyc, to);
    checks++; if ({to, bus.out_r} !== {1'b0, 32'd0}) begin errors++; $display("FAIL sltu_r: got %h (timeout %b) expected 00000000", bus.out_r, to); end
    checks++; if ({bus.out_zero, bus.out_carry, bus.out_negative} !== 3'b100) begin
      errors++; $display("FAIL sltu_flags: got z%b c%b n%b expected z1 c0 n0", bus.out_zero, bus.out_carry, bus.out_negative);
    end
    take();
    issue(32'h1C000E02, 32'hFFFFFFFF, 4'b1011, rdy);
    wait_out(4, cyc, to);
    checks++; if ({to, bus.out_r} !== {1'b0, 32'd0}) begin errors++; $display("FAIL slt_r: got %h (timeout %b) expected 00000000", bus.out_r, to); end
    checks++; if ({bus.out_negative, bus.out_zero, bus.out_carry} !== 3'b000) begin
      errors++; $display("FAIL slt_flags: got n%b z%b c%b expected n0 z0 c0", bus.out_negative, bus.out_zero, bus.out_carry);
    end
    take();
    checks++; if (op_count !== 4'd7) begin errors++; $display("FAIL slt_count: got %0d expected 7", op_count); end
  endtask

  task automatic test_back_to_back();
    logic rdy;
    int   cyc;
    bit   to;
    bus.out_ready = 1'b1;
    issue(32'd5, 32'd7, 4'b0000, rdy);
    checks++; if ({bus.out_valid, bus.out_r} !== {1'b1, 32'd12}) begin
      errors++; $display("FAIL early_ready_result: got valid=%b r=%h expected valid=1 r=0000000c", bus.out_valid, bus.out_r);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if ({bus.out_valid, bus.in_ready, op_count} !== {1'b0, 1'b1, 4'd8}) begin
      errors++; $display("FAIL early_ready_handshake: got valid=%b ready=%b count=%0d expected valid=0 ready=1 count=8",
                         bus.out_valid, bus.in_ready, op_count);
    end
    issue(32'h80000000, 32'd1, 4'b0011, rdy);
    wait_out(4, cyc, to);
    checks++; if ({to, bus.out_r, bus.out_overflow, bus.out_negative} !== {1'b0, 32'h7FFFFFFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_overflow: got r=%h v%b n%b (timeout %b) expected r=7fffffff v1 n0",
                         bus.out_r, bus.out_overflow, bus.out_negative, to);
    end
    take();
    issue(32'd32, 32'h80000001, 4'b1100, rdy);
    checks++; if ({busy, bus.out_valid} !== 2'b01) begin
      errors++; $display("FAIL shift_zero_latency: got busy=%b valid=%b expected busy=0 valid=1", busy, bus.out_valid);
    end
    checks++; if ({bus.out_r, bus.out_carry, bus.out_negative} !== {32'h80000001, 1'b0, 1'b1}) begin
      errors++; $display("FAIL shift_zero_result: got r=%h c%b n%b expected r=80000001 c0 n1", bus.out_r, bus.out_carry, bus.out_negative);
    end
    take();
  endtask

  task automatic test_shift_max();
    logic rdy;
    int   cyc;
    bit   to;
    issue(32'd31, 32'hC0000000, 4'b1101, rdy);
    wait_out(40, cyc, to);
    checks++; if (to || cyc != 31) begin errors++; $display("FAIL srl31_latency: got %0d cycles (timeout %b) expected 31", cyc, to); end
    checks++; if ({bus.out_r, bus.out_carry, bus.out_zero} !== {32'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL srl31_result: got r=%h c%b z%b expected r=00000001 c1 z0", bus.out_r, bus.out_carry, bus.out_zero);
    end
    take();
    checks++; if (op_count !== 4'd11) begin errors++; $display("FAIL srl31_count: got %0d expected 11", op_count); end
  endtask

  task automatic test_reset_mid_shift();
    logic rdy;
    int   cyc;
    bit   to;
    issue(32'd20, 32'hFFFF0000, 4'b1101, rdy);
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midshift_busy: got %b expected 1", busy); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.out_valid, busy, bus.in_ready, op_count} !== {3'b000, 4'd0}) begin
      errors++; $display("FAIL midshift_reset: got valid=%b busy=%b ready=%b count=%0d expected all 0",
                         bus.out_valid, busy, bus.in_ready, op_count);
    end
    checks++; if (bus.out_r !== 32'd0) begin errors++; $display("FAIL midshift_reset_r: got %h expected 00000000", bus.out_r); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midshift_release_ready: got %b expected 1", bus.in_ready); end
    issue(32'd1, 32'd1, 4'b0000, rdy);
    wait_out(4, cyc, to);
    checks++; if ({to, bus.out_r, bus.out_zero, bus.out_carry} !== {1'b0, 32'd2, 2'b00}) begin
      errors++; $display("FAIL post_reset_addu: got r=%h z%b c%b (timeout %b) expected r=00000002 z0 c0",
                         bus.out_r, bus.out_zero, bus.out_carry, to);
    end
    take();
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL post_reset_count: got %0d expected 1", op_count); end
  endtask

  task automatic test_count_wrap();
    logic rdy;
    int   n;
    n = 0;
    while (op_count != 4'd15 && n < 20) begin
      issue(32'd0, 32'd0, 4'b0100, rdy);
      take();
      n++;
    end
    checks++; if (op_count !== 4'd15 || n != 14) begin
      errors++; $display("FAIL wrap_reach_max: got count=%0d after %0d ops expected 15 after 14", op_count, n);
    end
    issue(32'd0, 32'd0, 4'b0100, rdy);
    take();
    checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL wrap_to_zero: got %0d expected 0", op_count); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_aluc   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_addu();
    test_add_subu();
    test_sra();
    test_sll_hold();
    test_slt();
    test_back_to_back();
    test_shift_max();
    test_reset_mid_shift();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
